// File: rtl/axis_rx_fifo_if.sv
// AXI4-Stream beat channel carrying 8-bit payload plus packet delimiter.
//   tdata  : stream payload, driven by the master
//   tvalid : master has a beat
//   tlast  : beat closes a packet
//   tready : slave can accept this cycle
interface axis_rx_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rx_fifo.sv
// AXI4-Stream receive endpoint: buffers beats in a first-word-fall-through FIFO,
// checks the incrementing byte pattern and counts beats/packets.
//   clk      : single rising-edge clock
//   reset    : synchronous active-high, clears all state
//   s_axis   : stream slave (tdata/tvalid/tlast in, tready out, registered)
//   rd_en    : consumer pops the head entry
//   rd_data  : head entry, combinational; 0 when empty
//   rd_valid : FIFO non-empty
//   level    : occupancy, 0..DEPTH
//   seq_err  : sticky data-sequence mismatch flag
//   beat_cnt : accepted beats, saturating
//   pkt_cnt  : accepted beats with tlast, saturating
module axis_rx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   axis_rx_fifo_if.slave              s_axis,
   input  logic                       rd_en,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       seq_err,
   output logic [15:0]                beat_cnt,
   output logic [15:0]                pkt_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = 16;

   typedef enum logic {SYNC, TRACK} seq_state_e;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  tready_q, tready_d;
   logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
   logic [CW-1:0]         pkt_cnt_q, pkt_cnt_d;
   logic                  accept_c, pop_c;

   seq_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] expected_q, expected_d;
   logic                  seq_err_q, seq_err_d;
   logic [DATA_WIDTH-1:0] cmp_val_c;

   // Handshake qualification; a pop while empty is dropped here.
   always_comb begin
      accept_c = s_axis.tvalid && tready_q;
      pop_c    = rd_en && (level_q != '0);
   end

   // Pointer, occupancy, tready and counter next-state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      beat_cnt_d = beat_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      if (accept_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (beat_cnt_q != {CW{1'b1}}) beat_cnt_d = beat_cnt_q + CW'(1);
         if (s_axis.tlast && (pkt_cnt_q != {CW{1'b1}})) pkt_cnt_d = pkt_cnt_q + CW'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({accept_c, pop_c})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // No bypass: readiness follows post-edge occupancy only.
      tready_d = (level_d < LW'(DEPTH));
   end

   // Datapath state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         tready_q   <= 1'b0;
         beat_cnt_q <= '0;
         pkt_cnt_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         tready_q   <= tready_d;
         beat_cnt_q <= beat_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   // Storage; contents are don't-care until written, empty reads are masked.
   always_ff @(posedge clk) begin
      if (accept_c) mem_q[wr_ptr_q] <= s_axis.tdata;
   end

   // Sequence checker state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SYNC;
         expected_q <= '0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         seq_err_q  <= seq_err_d;
      end
   end

   // Sequence checker next state: any accepted beat locks onto the stream.
   always_comb begin
      state_d = state_q;
      if (accept_c) state_d = TRACK;
   end

   // Sequence checker outputs: compare, then resync to the received value.
   always_comb begin
      expected_d = expected_q;
      seq_err_d  = seq_err_q;
      cmp_val_c  = (state_q == SYNC) ? '0 : expected_q;
      if (accept_c) begin
         if (s_axis.tdata != cmp_val_c) seq_err_d = 1'b1;
         expected_d = s_axis.tdata + DATA_WIDTH'(1);
      end
   end

   assign s_axis.tready = tready_q;
   assign rd_valid      = (level_q != '0);
   assign rd_data       = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign level         = level_q;
   assign seq_err       = seq_err_q;
   assign beat_cnt      = beat_cnt_q;
   assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rx_fifo.sv
// Directed bench for axis_rx_fifo with a scoreboard queue of expected read data.
module tb_axis_rx_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [2:0]  level;
   logic        seq_err;
   logic [15:0] beat_cnt;
   logic [15:0] pkt_cnt;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;
   logic        chk_le1 = 1'b0;

   axis_rx_fifo_if #(.DATA_WIDTH(8)) axis ();

   axis_rx_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .s_axis   (axis),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .level    (level),
      .seq_err  (seq_err),
      .beat_cnt (beat_cnt),
      .pkt_cnt  (pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every pop against the scoreboard, plus empty/level rules.
   always @(negedge clk) begin
      if (!reset) begin
         if (!rd_valid) check("rd_data_when_empty", 32'(rd_data), 0);
         if (chk_le1) check("level_le_1", 32'(level <= 3'd1), 1);
         if (rd_en && rd_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pop: got %0d required none", rd_data);
            end else begin
               mon_exp = exp_q.pop_front();
               check("rd_data_order", 32'(rd_data), 32'(mon_exp));
            end
         end
      end
   end

   // Drive one beat; push its expected value when the handshake is seen.
   task automatic send(input logic [7:0] d, input logic l);
      bit done = 1'b0;
      axis.tdata  = d;
      axis.tvalid = 1'b1;
      axis.tlast  = l;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (axis.tready === 1'b1) begin
            exp_q.push_back(d);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      axis.tvalid = 1'b0;
      axis.tlast  = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: beat %0d not accepted, required accept within 20 cycles", d);
      end
   endtask

   task automatic do_reset(input int n);
      reset       = 1'b1;
      axis.tvalid = 1'b0;
      axis.tlast  = 1'b0;
      rd_en       = 1'b0;
      exp_q.delete();
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      check("tready_in_reset", 32'(axis.tready), 0);
      @(posedge clk);
      #1;
      check("tready_after_release", 32'(axis.tready), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      rd_en       = 1'b0;
      axis.tdata  = '0;
      axis.tvalid = 1'b0;
      axis.tlast  = 1'b0;

      // Reset values, then release and stream 0..9 with the consumer popping.
      @(posedge clk);
      @(negedge clk);
      check("rst_tready", 32'(axis.tready), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_level", 32'(level), 0);
      check("rst_seq_err", 32'(seq_err), 0);
      check("rst_beat_cnt", 32'(beat_cnt), 0);
      check("rst_pkt_cnt", 32'(pkt_cnt), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("tready_before_first_edge", 32'(axis.tready), 0);
      @(posedge clk);
      #1;
      check("tready_one_cycle_after", 32'(axis.tready), 1);
      rd_en   = 1'b1;
      chk_le1 = 1'b1;
      for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_le1 = 1'b0;
      check("t1_beat_cnt", 32'(beat_cnt), 10);
      check("t1_seq_err", 32'(seq_err), 0);
      check("t1_level", 32'(level), 0);
      check("t1_pkt_cnt", 32'(pkt_cnt), 0);
      check("t1_sb_empty", 32'(exp_q.size()), 0);

      // Fill to full, hold off beat 4, single pop releases it.
      do_reset(1);
      for (int i = 0; i < 4; i++) send(8'(i), 1'b0);
      check("full_tready", 32'(axis.tready), 0);
      check("full_level", 32'(level), 4);
      check("full_head", 32'(rd_data), 0);
      fork
         send(8'd4, 1'b0);
         begin
            repeat (2) begin
               @(negedge clk);
               check("held_off_tready", 32'(axis.tready), 0);
               check("held_off_level", 32'(level), 4);
            end
            @(posedge clk);
            #1;
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            check("after_pop_tready", 32'(axis.tready), 1);
            check("after_pop_level", 32'(level), 3);
         end
      join
      check("refill_level", 32'(level), 4);
      check("refill_tready", 32'(axis.tready), 0);
      check("refill_beat_cnt", 32'(beat_cnt), 5);
      check("refill_head", 32'(rd_data), 1);
      rd_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rd_en = 1'b0;
      check("drained_level", 32'(level), 0);
      check("drained_rd_valid", 32'(rd_valid), 0);
      check("t2_sb_empty", 32'(exp_q.size()), 0);

      // Sequence error on 7, no further error on 8, cleared by reset.
      do_reset(1);
      rd_en = 1'b1;
      begin
         logic [7:0] seq_d [5];
         logic       seq_e [5];
         seq_d = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8};
         seq_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
         for (int i = 0; i < 5; i++) begin
            send(seq_d[i], 1'b0);
            check("seq_err_step", 32'(seq_err), 32'(seq_e[i]));
         end
      end
      check("t3_beat_cnt", 32'(beat_cnt), 5);
      do_reset(1);
      check("seq_err_cleared", 32'(seq_err), 0);

      // Walk up to 253, then 254,255,0,1 across the wrap with two tlasts.
      rd_en = 1'b1;
      for (int i = 0; i < 254; i++) send(8'(i), 1'b0);
      check("pre_wrap_seq_err", 32'(seq_err), 0);
      send(8'd254, 1'b0);
      send(8'd255, 1'b1);
      send(8'd0, 1'b0);
      check("wrap_seq_err", 32'(seq_err), 0);
      send(8'd1, 1'b1);
      check("post_wrap_seq_err", 32'(seq_err), 0);
      check("wrap_pkt_cnt", 32'(pkt_cnt), 2);
      check("wrap_beat_cnt", 32'(beat_cnt), 258);
      repeat (2) @(posedge clk);
      #1;
      check("t4_sb_empty", 32'(exp_q.size()), 0);

      // Reset while holding three entries.
      do_reset(1);
      for (int i = 0; i < 3; i++) send(8'(i), 1'b0);
      check("pre_rst_level", 32'(level), 3);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("mid_rst_level", 32'(level), 0);
      check("mid_rst_rd_valid", 32'(rd_valid), 0);
      check("mid_rst_rd_data", 32'(rd_data), 0);
      check("mid_rst_beat_cnt", 32'(beat_cnt), 0);
      check("mid_rst_pkt_cnt", 32'(pkt_cnt), 0);
      check("mid_rst_tready", 32'(axis.tready), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_tready_back", 32'(axis.tready), 1);

      // Simultaneous accept and pop at level 2.
      send(8'd0, 1'b0);
      send(8'd1, 1'b0);
      check("sim_level_start", 32'(level), 2);
      rd_en = 1'b1;
      for (int i = 2; i < 5; i++) begin
         send(8'(i), 1'b0);
         check("sim_level_hold", 32'(level), 2);
      end
      repeat (2) @(posedge clk);
      #1;
      rd_en = 1'b0;
      check("sim_level_end", 32'(level), 0);
      check("sim_seq_err", 32'(seq_err), 0);
      check("t6_sb_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
